// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE feeder: default widths and FSM state encoding.
package pe_feeder_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_WEIGHT_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH    = 8;
  localparam int unsigned DEF_PE_LATENCY   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Pixel source handshake bundle.
//   pix_in_data  : pixel value, source -> feeder
//   pix_in_valid : source has a pixel
//   pix_in_ready : feeder accepts a pixel this cycle
interface pe_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] pix_in_data;
  logic                  pix_in_valid;
  logic                  pix_in_ready;

  modport master (output pix_in_data, output pix_in_valid, input pix_in_ready);
  modport slave  (input pix_in_data, input pix_in_valid, output pix_in_ready);

endinterface

// File: rtl/pe_valid_delay.sv
// {en,last} delay line matching the PE pipeline latency.
//   en_i/last_i   : flags launched alongside pe_en
//   en_o/last_o   : flags DEPTH edges later (registered)
//   en_pre_o      : en one stage before en_o, used to time result capture
module pe_valid_delay #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic last_i,
  output logic en_o,
  output logic last_o,
  output logic en_pre_o
);

  logic [DEPTH-1:0] en_q, en_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    en_d   = {en_q[DEPTH-2:0], en_i};
    last_d = {last_q[DEPTH-2:0], last_i & en_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      last_q <= '0;
    end else begin
      en_q   <= en_d;
      last_q <= last_d;
    end
  end

  assign en_o     = en_q[DEPTH-1];
  assign last_o   = last_q[DEPTH-1];
  assign en_pre_o = en_q[DEPTH-2];

endmodule

// File: rtl/pe_feeder.sv
// Feeds a frame of pixels into a pipelined PE and collects its products.
//   clk, rst                  : clock, async active-high reset
//   cfg_weight/_valid         : weight load (IDLE only)
//   start, frame_len          : frame kick-off and pixel count (IDLE only)
//   pix_if                    : pixel source handshake
//   pe_input/pe_weight/pe_en  : drive to the PE
//   pe_output                 : PE product
//   res_data/valid/last       : result stream, no backpressure
//   busy, done                : status; done is a one-cycle pulse
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int unsigned PE_LATENCY   = DEF_PE_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WEIGHT_WIDTH-1:0]            cfg_weight,
  input  logic                               cfg_weight_valid,
  input  logic                               start,
  input  logic [LEN_WIDTH-1:0]               frame_len,
  pe_feeder_if.slave                         pix_if,
  output logic [DATA_WIDTH-1:0]              pe_input,
  output logic [WEIGHT_WIDTH-1:0]            pe_weight,
  output logic                               pe_en,
  input  logic [DATA_WIDTH+WEIGHT_WIDTH-1:0] pe_output,
  output logic [DATA_WIDTH+WEIGHT_WIDTH-1:0] res_data,
  output logic                               res_valid,
  output logic                               res_last,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic [DATA_WIDTH-1:0]   pe_input_q, pe_input_d;
  logic                    pe_en_q, pe_en_d;
  logic                    pe_last_q, pe_last_d;
  logic [PROD_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    xfer;
  logic                    dly_en, dly_last, dly_en_pre;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    weight_d   = weight_q;
    pe_input_d = pe_input_q;
    pe_en_d    = 1'b0;
    pe_last_d  = 1'b0;
    xfer       = ready_q & pix_if.pix_in_valid;
    // Product is valid at pe_output exactly when the en bit is one stage from the tap.
    res_data_d = dly_en_pre ? pe_output : res_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_weight_valid) weight_d = cfg_weight;
        if (start) begin
          len_d   = frame_len;
          cnt_d   = '0;
          state_d = (frame_len != '0) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          pe_input_d = pix_if.pix_in_data;
          pe_en_d    = 1'b1;
          cnt_d      = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            pe_last_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (dly_en && dly_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status flops track the state being entered so they align with it.
    busy_d  = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      weight_q   <= '0;
      pe_input_q <= '0;
      pe_en_q    <= 1'b0;
      pe_last_q  <= 1'b0;
      res_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      weight_q   <= weight_d;
      pe_input_q <= pe_input_d;
      pe_en_q    <= pe_en_d;
      pe_last_q  <= pe_last_d;
      res_data_q <= res_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  // One extra stage beyond the PE latency covers the res_data register.
  pe_valid_delay #(
    .DEPTH (PE_LATENCY + 1)
  ) u_valid_delay (
    .clk      (clk),
    .rst      (rst),
    .en_i     (pe_en_q),
    .last_i   (pe_last_q),
    .en_o     (dly_en),
    .last_o   (dly_last),
    .en_pre_o (dly_en_pre)
  );

  assign pix_if.pix_in_ready = ready_q;
  assign pe_input            = pe_input_q;
  assign pe_weight           = weight_q;
  assign pe_en               = pe_en_q;
  assign res_data            = res_data_q;
  assign res_valid           = dly_en;
  assign res_last            = dly_last;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
